// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: start/operand/result bundle between the execute
// stage (master) and the iterative multiply/divide unit (slave).
//   master drives : ctrl_MULT, ctrl_DIV, data_operandA, data_operandB
//   slave drives  : data_result, data_exception, data_resultRDY, busy
interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT,
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_MULT,
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-bit multiply (shift-add) and
// divide (restoring), 32 iterations each, one-cycle result strobe.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of multdiv_unit_if
//             in  ctrl_MULT/ctrl_DIV start pulses, operands A/B
//             out data_result, data_exception, data_resultRDY, busy
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input logic           clock,
    input logic           reset_n,
    multdiv_unit_if.slave bus
);

    localparam int         W2   = 2 * WIDTH;
    localparam logic [5:0] LAST = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    // mult: {partial product, multiplier}
    // div : {remainder, dividend/quotient}
    logic [W2-1:0]    acc_q, acc_d;
    // mult: |A| (added); div: |B| (subtracted)
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             mul_q, mul_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic             start;
    logic             start_dz;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_nxt;
    logic [WIDTH:0]   sh_rem;
    logic [WIDTH:0]   trial;
    logic [W2-1:0]    div_nxt;

    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] fin_res;
    logic             fin_exc;

    // Both controls high at once is not a start.
    assign start    = bus.ctrl_MULT ^ bus.ctrl_DIV;
    assign start_dz = bus.ctrl_DIV & (bus.data_operandB == '0);

    assign a_neg = bus.data_operandA[WIDTH-1];
    assign b_neg = bus.data_operandB[WIDTH-1];
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    assign mag_a = a_neg ? -bus.data_operandA : bus.data_operandA;
    assign mag_b = b_neg ? -bus.data_operandB : bus.data_operandB;

    // Shift-add step: conditional add into the upper half, carry kept
    // so the right shift brings it back in at the top.
    assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: remainder < |B| so the shifted value is < 2|B|,
    // and bit WIDTH of the trial difference is a clean borrow flag.
    assign sh_rem  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign trial   = sh_rem - {1'b0, opnd_q};
    assign div_nxt = trial[WIDTH]
                   ? {sh_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    // Sign fix-up applied when leaving DONE.
    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_comb begin
        fin_res = '0;
        fin_exc = 1'b0;
        if (dz_q) begin
            fin_res = '0;
            fin_exc = 1'b1;
        end else if (mul_q) begin
            fin_res = prod[WIDTH-1:0];
            fin_exc = prod[W2-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
        end else begin
            fin_res = quo;
            fin_exc = ovf_q;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a start in any state (re)launches; divide by zero
    // skips the iterations entirely.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = start_dz ? DONE : RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     state_d = (cnt_q == LAST) ? DONE : RUN;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.busy           = state_q != IDLE;
        bus.data_result    = res_q;
        bus.data_exception = exc_q;
        bus.data_resultRDY = rdy_q;
    end

    // Datapath next state. DONE is the final cycle of an operation,
    // so its result is published even if a new start lands on the
    // same edge; a start during RUN simply overwrites the datapath.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        mul_d  = mul_q;
        neg_d  = neg_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
        res_d  = res_q;
        exc_d  = exc_q;
        rdy_d  = 1'b0;

        if (state_q == DONE) begin
            res_d = fin_res;
            exc_d = fin_exc;
            rdy_d = 1'b1;
        end

        if (start) begin
            cnt_d  = '0;
            mul_d  = bus.ctrl_MULT;
            neg_d  = a_neg ^ b_neg;
            dz_d   = start_dz;
            ovf_d  = bus.ctrl_DIV
                   & (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                   & (bus.data_operandB == {WIDTH{1'b1}});
            opnd_d = bus.ctrl_MULT ? mag_a : mag_b;
            acc_d  = {{WIDTH{1'b0}}, bus.ctrl_MULT ? mag_b : mag_a};
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 6'd1;
            acc_d = mul_q ? mul_nxt : div_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            mul_q  <= 1'b0;
            neg_q  <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            res_q  <= '0;
            exc_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            mul_q  <= mul_d;
            neg_q  <= neg_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
            res_q  <= res_d;
            exc_q  <= exc_d;
            rdy_q  <= rdy_d;
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench for multdiv_unit.
// Expected results/strobe edges are queued at start and popped on RDY.
module tb_multdiv_unit;

    logic clock;
    logic reset_n;

    multdiv_unit_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          at;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          cyc        = 0;
    int          last_start = 0;
    int          last_end   = 0;
    int          n_chk      = 0;
    int          n_fail     = 0;
    logic        exp_rdy;
    logic [31:0] last_res   = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] model(input logic mul,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] p;
        logic [31:0]        r;
        logic               e;
        if (mul) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r = p[31:0];
            e = p[63:32] != {32{p[31]}};
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = $signed(a) / $signed(b);
            e = 1'b0;
        end
        return {e, r};
    endfunction

    // Monitor: strobe timing, busy window, and result/exception.
    initial forever begin
        @(posedge clock);
        cyc++;
        #1;
        exp_rdy = (sb_q.size() > 0) && (sb_q[0].at == cyc);
        chk("rdy", bus.data_resultRDY, exp_rdy);
        chk("busy", bus.busy, (cyc >= last_start) && (cyc < last_end));
        if (exp_rdy) begin
            cur = sb_q.pop_front();
            chk("result", bus.data_result, cur.res);
            chk("exception", bus.data_exception, cur.exc);
            last_res = cur.res;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives a start for the next rising edge k; anything still
    // pending past edge k is an aborted operation and never strobes.
    task automatic start_op(input logic mul,
                            input logic [31:0] a,
                            input logic [31:0] b);
        int          k;
        logic [32:0] m;
        exp_t        e;
        @(negedge clock);
        k = cyc + 1;
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = !mul;
        bus.data_operandA = a;
        bus.data_operandB = b;
        while (sb_q.size() > 0 && sb_q[$].at > k) void'(sb_q.pop_back());
        m     = model(mul, a, b);
        e.at  = k + ((!mul && b == 32'd0) ? 1 : 33);
        e.res = m[31:0];
        e.exc = m[32];
        sb_q.push_back(e);
        last_start = k;
        last_end   = e.at;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clock);
        chk("drain", sb_q.size(), 0);
        wait_cyc(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        #3;
        chk("rst_result", bus.data_result, 0);
        chk("rst_exc", bus.data_exception, 0);
        chk("rst_rdy", bus.data_resultRDY, 0);
        chk("rst_busy", bus.busy, 0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(1);

        start_op(1'b1, 32'd7, -32'sd6);
        wait_idle();
        wait_cyc(5);
        chk("hold", bus.data_result, last_res);

        start_op(1'b1, 32'h0001_0000, 32'h0001_0000);
        wait_idle();
        start_op(1'b1, 32'h8000_0000, 32'd1);
        wait_idle();
        start_op(1'b0, -32'sd7, 32'd2);
        wait_idle();
        start_op(1'b0, 32'd100, 32'd0);
        wait_idle();
        start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // Restart mid-run: only the divide strobes.
        start_op(1'b1, 32'd3, 32'd4);
        wait_cyc(9);
        start_op(1'b0, 32'd20, 32'd5);
        wait_idle();

        // Back-to-back: new start on the edge that raises RDY.
        start_op(1'b1, -32'sd9, -32'sd9);
        wait_cyc(31);
        start_op(1'b0, 32'd1000, -32'sd7);
        wait_idle();

        // Both controls high: ignored.
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.ctrl_DIV  = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        wait_cyc(40);

        // Reset in the middle of RUN.
        start_op(1'b1, 32'd12345, 32'd678);
        wait_cyc(14);
        #2;
        reset_n = 1'b0;
        sb_q.delete();
        last_start = 0;
        last_end   = 0;
        #1;
        chk("mid_rst_result", bus.data_result, 0);
        chk("mid_rst_exc", bus.data_exception, 0);
        chk("mid_rst_rdy", bus.data_resultRDY, 0);
        chk("mid_rst_busy", bus.busy, 0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(40);

        start_op(1'b1, 32'd2, 32'd3);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            start_op(i[0], $urandom, (i < 3) ? $urandom_range(1, 300) : $urandom);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
